// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared types and default sizes for the GPIO responder slice.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    typedef enum logic {
        IDLE,
        SETTLING
    } dbnc_state_t;

    localparam int GPIO_WIDTH           = 32;
    localparam int GPIO_SYNC_STAGES     = 2;
    localparam int GPIO_DEBOUNCE_CYCLES = 4;

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_responder_if
// Description : CPU-side strobe/data bundle between control unit and GPIO.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_responder_if #(
    parameter int WIDTH = 32
);
    logic             gpio_out_en;
    logic [WIDTH-1:0] gpio_wdata;
    logic             gpio_in_en;
    logic [WIDTH-1:0] gpio_rdata;
    logic             gpio_rvalid;

    modport master (
        output gpio_out_en,
        output gpio_wdata,
        output gpio_in_en,
        input  gpio_rdata,
        input  gpio_rvalid
    );

    modport slave (
        input  gpio_out_en,
        input  gpio_wdata,
        input  gpio_in_en,
        output gpio_rdata,
        output gpio_rvalid
    );
endinterface : gpio_responder_if
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module      : gpio_debounce
// Description : Per-word debounce FSM; commits a candidate after it has been
//               stable for DEBOUNCE_CYCLES consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] sync_q,
    output logic      [WIDTH-1:0] stable,
    output logic                  changed_pulse
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    dbnc_state_t      r_state;
    logic             w_commit;

    assign w_commit      = (r_state == SETTLING) && (sync_q == r_cand) && (r_cnt == CNT_LAST);
    // High in the cycle before the edge on which stable takes a new value.
    assign changed_pulse = w_commit && (r_cand != stable);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand  <= '0;
            r_cnt   <= '0;
            stable  <= '0;
            r_state <= IDLE;
        end else if (sync_q != r_cand) begin
            r_cand  <= sync_q;
            r_cnt   <= '0;
            r_state <= SETTLING;
        end else if (r_state == SETTLING) begin
            if (r_cnt == CNT_LAST) begin
                stable  <= r_cand;
                r_state <= IDLE;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : gpio_debounce
`default_nettype wire

// File: rtl/gpio_responder.sv
`default_nettype none
// ============================================================================
// Module      : gpio_responder
// Description : GPIO output register, synchronised/debounced input read-back
//               and sticky change flag. GPIO_LOOPBACK_EN feeds pins_out into
//               the synchroniser for self-test.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_responder
    import gpio_pkg::*;
#(
    parameter int WIDTH           = GPIO_WIDTH,
    parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  wire logic             clk,
    input  wire logic             rst,
    gpio_responder_if.slave       bus,
    input  wire logic [WIDTH-1:0] pins_in,
    output logic      [WIDTH-1:0] pins_out,
    output logic                  change_irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_sync_d;
    logic [WIDTH-1:0]                  w_sync_q;
    logic [WIDTH-1:0]                  w_stable;
    logic                              w_changed;

`ifdef GPIO_LOOPBACK_EN
    assign w_sync_d = pins_out;
`else
    assign w_sync_d = pins_in;
`endif

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_sync_d};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pins_out <= '0;
        end else if (bus.gpio_out_en) begin
            pins_out <= bus.gpio_wdata;
        end
    end

    gpio_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .sync_q        (w_sync_q),
        .stable        (w_stable),
        .changed_pulse (w_changed)
    );

    // A commit on the same edge as a read keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.gpio_rdata  <= '0;
            bus.gpio_rvalid <= 1'b0;
            change_irq      <= 1'b0;
        end else begin
            bus.gpio_rvalid <= bus.gpio_in_en;
            if (bus.gpio_in_en) begin
                bus.gpio_rdata <= w_stable;
            end
            if (w_changed) begin
                change_irq <= 1'b1;
            end else if (bus.gpio_in_en) begin
                change_irq <= 1'b0;
            end
        end
    end

endmodule : gpio_responder
`default_nettype wire

// File: tb/tb_gpio_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_responder
// Description : Directed self-checking bench; read results via scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_responder;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] pins_in;
    logic [W-1:0] pins_out;
    logic         change_irq;

    int           tests_run;
    int           tests_failed;
    logic [W-1:0] sb[$];

    gpio_responder_if #(.WIDTH(W)) bus ();

    gpio_responder #(
        .WIDTH           (W),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pins_in    (pins_in),
        .pins_out   (pins_out),
        .change_irq (change_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every rvalid pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (bus.gpio_rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                check("rdata", bus.gpio_rdata, sb.pop_front());
            end
        end
    end

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst             = 1'b0;
        pins_in         = '0;
        bus.gpio_out_en = 1'b0;
        bus.gpio_wdata  = '0;
        bus.gpio_in_en  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_pins_out", pins_out, '0);
        check("rst_rdata", bus.gpio_rdata, '0);
        check("rst_rvalid", {31'd0, bus.gpio_rvalid}, '0);
        check("rst_irq", {31'd0, change_irq}, '0);
        rst = 1'b1;
        tick();

        // 1: write, hold, async reset
        bus.gpio_out_en = 1'b1;
        bus.gpio_wdata  = 32'hA5A5_0F0F;
        tick();
        bus.gpio_out_en = 1'b0;
        bus.gpio_wdata  = 32'h0;
        check("wr_pins_out", pins_out, 32'hA5A5_0F0F);
        tick();
        check("wr_hold", pins_out, 32'hA5A5_0F0F);
        #2 rst = 1'b0;
        #1 check("async_rst_pins_out", pins_out, '0);
        tick();
        rst = 1'b1;
        tick();

`ifdef GPIO_LOOPBACK_EN
        // 6: loopback self-test, pins_in tied low
        pins_in         = '0;
        bus.gpio_out_en = 1'b1;
        bus.gpio_wdata  = 32'hDEAD_BEEF;
        tick();
        bus.gpio_out_en = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) check("lb_irq_before", {31'd0, change_irq}, '0);
            if (i == 7) check("lb_irq_commit", {31'd0, change_irq}, 32'd1);
        end
        bus.gpio_in_en = 1'b1;
        sb.push_back(32'hDEAD_BEEF);
        tick();
        bus.gpio_in_en = 1'b0;
        check("lb_irq_clr", {31'd0, change_irq}, '0);
`else
        // 2: single-bit change commits at edge 7
        pins_in = 32'h0000_0001;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) check("t2_irq_edge6", {31'd0, change_irq}, '0);
            if (i == 7) check("t2_irq_edge7", {31'd0, change_irq}, 32'd1);
        end
        bus.gpio_in_en = 1'b1;
        sb.push_back(32'h1);
        tick();
        bus.gpio_in_en = 1'b0;
        check("t2_irq_clr", {31'd0, change_irq}, '0);
        tick();
        check("t2_rvalid_low", {31'd0, bus.gpio_rvalid}, '0);

        // 3: settle back to 0, then a 3-cycle bounce is rejected
        pins_in = '0;
        repeat (10) tick();
        bus.gpio_in_en = 1'b1;
        sb.push_back(32'h0);
        tick();
        bus.gpio_in_en = 1'b0;
        pins_in = 32'h0000_0001;
        repeat (3) tick();
        pins_in = '0;
        repeat (12) tick();
        check("t3_irq_bounce", {31'd0, change_irq}, '0);
        bus.gpio_in_en = 1'b1;
        sb.push_back(32'h0);
        tick();
        bus.gpio_in_en = 1'b0;

        // 4: read on the commit edge returns old value, flag survives
        pins_in = 32'h0000_00FF;
        repeat (6) tick();
        check("t4_irq_pre", {31'd0, change_irq}, '0);
        bus.gpio_in_en = 1'b1;
        sb.push_back(32'h0);
        tick();
        check("t4_irq_set_wins", {31'd0, change_irq}, 32'd1);
        sb.push_back(32'hFF);
        tick();
        bus.gpio_in_en = 1'b0;
        check("t4_irq_clr", {31'd0, change_irq}, '0);

        // 5: simultaneous write and read
        pins_in = 32'h0000_0055;
        repeat (10) tick();
        check("t5_irq_set", {31'd0, change_irq}, 32'd1);
        bus.gpio_out_en = 1'b1;
        bus.gpio_wdata  = 32'h0000_1234;
        bus.gpio_in_en  = 1'b1;
        sb.push_back(32'h55);
        tick();
        bus.gpio_out_en = 1'b0;
        bus.gpio_in_en  = 1'b0;
        check("t5_pins_out", pins_out, 32'h0000_1234);
        check("t5_irq_clr", {31'd0, change_irq}, '0);
`endif

        repeat (3) tick();
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        tests_failed++;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_gpio_responder
`default_nettype wire
